// File: rtl/mips_ins_encoder.sv
// Program loader: encodes symbolic MIPS requests into 32-bit words, queues them with byte
// addresses in a show-ahead FIFO and streams them to imem. Optional macro: MIPS_ENC_BRANCH_REL_EN.
module mips_ins_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              err,
  output logic              err_sticky,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready; the producer
  // holds valid and payload until then, and ready never depends on the same-cycle valid.

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;
  localparam logic [3:0] OP_NOP  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;

  logic [31:0]       mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_n;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_n;

  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept;
  logic              push;
  logic              pop;
  logic              head_from_push;

`ifdef MIPS_ENC_BRANCH_REL_EN
  // Branch offset is relative to the delay-slot pc, in words.
  logic [15:0] beq_diff;
  logic [15:0] beq_rel;
  logic        unused_tgt_low;
  assign beq_diff       = in_imm - (pc[15:0] + 16'd4);
  assign beq_rel        = {{2{beq_diff[15]}}, beq_diff[15:2]};
  assign unused_tgt_low = ^in_target[1:0];
`endif

  always_comb begin
    enc_word    = 32'h0;
    enc_illegal = 1'b0;
    case (in_op)
      OP_ADD:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      OP_SUB:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      OP_AND:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
      OP_OR:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
      OP_SLT:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
      OP_ADDI: enc_word = {6'b001000, in_rs, in_rt, in_imm};
      OP_LW:   enc_word = {6'b100011, in_rs, in_rt, in_imm};
      OP_SW:   enc_word = {6'b101011, in_rs, in_rt, in_imm};
`ifdef MIPS_ENC_BRANCH_REL_EN
      OP_BEQ: begin
        enc_word    = {6'b000100, in_rs, in_rt, beq_rel};
        enc_illegal = (in_imm[1:0] != 2'b00);
      end
      OP_J:    enc_word = {6'b000010, pc[27:26], in_target[25:2]};
`else
      OP_BEQ:  enc_word = {6'b000100, in_rs, in_rt, in_imm};
      OP_J:    enc_word = {6'b000010, in_target};
`endif
      OP_NOP:  enc_word = 32'h0;
      default: enc_illegal = 1'b1;
    endcase
  end

  assign in_ready  = (state == S_LOAD) && (count < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign push      = accept && !enc_illegal;
  assign pop       = out_valid && out_ready;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_comb begin
    count_n  = count;
    rd_ptr_n = rd_ptr;
    if (push && !pop) count_n = count + CNT_W'(1);
    if (pop && !push) count_n = count - CNT_W'(1);
    if (pop)          rd_ptr_n = rd_ptr + PTR_W'(1);
    // When the new head slot is the one being written this edge, take the word directly.
    head_from_push = push && (count_n == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= enc_word;
      mem_addr[wr_ptr] <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      err        <= accept && enc_illegal;
      err_sticky <= err_sticky | (accept && enc_illegal);

      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= base_addr;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (push) pc <= pc + ADDR_W'(4);
          if (accept && in_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (count == '0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;

      out_valid <= (count_n != '0);
      if (count_n == '0) begin
        out_addr <= '0;
        out_data <= '0;
      end else if (head_from_push) begin
        out_addr <= pc;
        out_data <= enc_word;
      end else begin
        out_addr <= mem_addr[rd_ptr_n];
        out_data <= mem_data[rd_ptr_n];
      end
    end
  end

endmodule
